// File: rtl/store_buffer_if.sv
// store_buffer_if: EX-stage store port, data-memory drain port and MEM-stage load probe
interface store_buffer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  st_valid;
    logic                  st_ready;
    logic [1:0]            st_size;
    logic [ADDR_W-1:0]     st_addr;
    logic [DATA_W-1:0]     st_data;
    logic                  st_ades;
    logic                  mem_req;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_ack;
    logic                  ld_check;
    logic [ADDR_W-1:0]     ld_addr;
    logic                  ld_conflict;
    modport master (
        output st_valid, st_size, st_addr, st_data, mem_ack, ld_check, ld_addr,
        input  st_ready, st_ades, mem_req, mem_addr, mem_wstrb, mem_wdata, ld_conflict
    );
    modport slave (
        input  st_valid, st_size, st_addr, st_data, mem_ack, ld_check, ld_addr,
        output st_ready, st_ades, mem_req, mem_addr, mem_wstrb, mem_wdata, ld_conflict
    );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: formats EX-stage stores into strobed beats, queues them in order and drains to memory
module store_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    store_buffer_if.slave            bus,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int SB = DATA_W / 8;
    localparam int OB = $clog2(SB);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] addr_q  [DEPTH];
    logic [ADDR_W-1:0] addr_d  [DEPTH];
    logic [SB-1:0]     wstrb_q [DEPTH];
    logic [SB-1:0]     wstrb_d [DEPTH];
    logic [DATA_W-1:0] wdata_q [DEPTH];
    logic [DATA_W-1:0] wdata_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [PW:0]       count_q, count_d;
    logic              misaligned, push, pop;
    logic [SB-1:0]     base, st_wstrb;
    logic [DATA_W-1:0] st_wdata;

    always_comb begin
        misaligned = bus.st_size == 2'b01 ? bus.st_addr[0] :
                     bus.st_size == 2'b10 ? |bus.st_addr[1:0] :
                     bus.st_size == 2'b11 ? (DATA_W == 32 || |bus.st_addr[2:0]) : 1'b0;
        base = bus.st_size == 2'b00 ? SB'(1) :
               bus.st_size == 2'b01 ? SB'(3) :
               bus.st_size == 2'b10 ? SB'(15) : SB'(255);
        st_wstrb = base << bus.st_addr[OB-1:0];
        st_wdata = '0;
        for (int i = 0; i < SB; i++)
            st_wdata[8*i +: 8] = bus.st_size == 2'b00 ? bus.st_data[7:0] :
                                 bus.st_size == 2'b01 ? bus.st_data[8*(i%2) +: 8] :
                                 bus.st_size == 2'b10 ? bus.st_data[8*(i%4) +: 8] :
                                                        bus.st_data[8*i +: 8];
    end

    assign empty        = count_q == '0;
    assign count        = count_q;
    assign bus.st_ready = count_q != (PW+1)'(DEPTH);
    assign bus.st_ades  = bus.st_valid && misaligned;
    assign bus.mem_req  = !empty;
    assign bus.mem_addr  = addr_q[head_q];
    assign bus.mem_wstrb = wstrb_q[head_q];
    assign bus.mem_wdata = wdata_q[head_q];
    assign push = bus.st_valid && bus.st_ready && !misaligned;
    assign pop  = bus.mem_req && bus.mem_ack;

    always_comb begin
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (push) begin
            addr_d[tail_q]  = {bus.st_addr[ADDR_W-1:OB], {OB{1'b0}}};
            wstrb_d[tail_q] = st_wstrb;
            wdata_d[tail_q] = st_wdata;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PW'(1);
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end
        count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    // whole-beat match: any pending store in the same DATA_W-aligned beat blocks the load
    always_comb begin
        bus.ld_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (valid_q[i] && ((addr_q[i] ^ bus.ld_addr) >> OB) == '0)
                bus.ld_conflict = bus.ld_check;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                wstrb_q[i] <= '0;
                wdata_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: vector table plus in-order scoreboard for 32-bit and 64-bit store buffers
module tb_store_buffer;
    logic clk = 0;
    logic resetn = 0;
    logic       empty32, empty64;
    logic [2:0] count32, count64;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic        ades;
        logic [31:0] eaddr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } vec_t;
    typedef struct {
        logic [63:0] addr;
        logic [7:0]  strb;
        logic [63:0] data;
    } exp_t;
    vec_t vt[10];
    exp_t sq[$];
    exp_t popped;

    store_buffer_if #(.DATA_W(32), .ADDR_W(32)) b32();
    store_buffer_if #(.DATA_W(64), .ADDR_W(32)) b64();

    store_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut32 (
        .clk(clk), .resetn(resetn), .bus(b32), .empty(empty32), .count(count32));
    store_buffer #(.DATA_W(64), .ADDR_W(32), .DEPTH(4)) dut64 (
        .clk(clk), .resetn(resetn), .bus(b64), .empty(empty64), .count(count64));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic chk_head(input string n, input logic req, input logic [63:0] a,
                            input logic [7:0] s, input logic [63:0] d);
        if (sq.size() == 0) chk({n, "_sb_underflow"}, 64'(req), 64'd0);
        else begin
            chk({n, "_req"}, 64'(req), 64'd1);
            chk({n, "_addr"}, a, sq[0].addr);
            chk({n, "_strb"}, 64'(s), 64'(sq[0].strb));
            chk({n, "_data"}, d, sq[0].data);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive64(input logic [1:0] sz, input logic [31:0] a, input logic [63:0] d,
                           input logic ades, input logic [31:0] ea, input logic [7:0] s,
                           input logic [63:0] wd);
        b64.st_valid = 1; b64.st_size = sz; b64.st_addr = a; b64.st_data = d;
        @(negedge clk);
        chk("ades64", 64'(b64.st_ades), 64'(ades));
        if (!ades) sq.push_back('{64'(ea), s, wd});
        tick;
        b64.st_valid = 0;
    endtask

    initial begin
        vt[0] = '{2'b00, 32'h1003, 32'h000000A5, 0, 32'h1000, 4'b1000, 32'hA5A5A5A5};
        vt[1] = '{2'b01, 32'h2001, 32'h00001234, 1, 32'h0,    4'b0000, 32'h0};
        vt[2] = '{2'b11, 32'h2000, 32'h12345678, 1, 32'h0,    4'b0000, 32'h0};
        vt[3] = '{2'b01, 32'h1002, 32'h0000CAFE, 0, 32'h1000, 4'b1100, 32'hCAFECAFE};
        vt[4] = '{2'b10, 32'h1008, 32'hDEADBEEF, 0, 32'h1008, 4'b1111, 32'hDEADBEEF};
        vt[5] = '{2'b10, 32'h100A, 32'hDEADBEEF, 1, 32'h0,    4'b0000, 32'h0};
        vt[6] = '{2'b00, 32'h1000, 32'h00000012, 0, 32'h1000, 4'b0001, 32'h12121212};
        vt[7] = '{2'b01, 32'h1000, 32'h00005678, 0, 32'h1000, 4'b0011, 32'h56785678};
        vt[8] = '{2'b00, 32'h1001, 32'hFFFFFF3C, 0, 32'h1000, 4'b0010, 32'h3C3C3C3C};
        vt[9] = '{2'b01, 32'h1003, 32'h0000FFFF, 1, 32'h0,    4'b0000, 32'h0};

        b32.st_valid = 0; b32.st_size = 0; b32.st_addr = 0; b32.st_data = 0;
        b32.mem_ack = 0; b32.ld_check = 1; b32.ld_addr = 0;
        b64.st_valid = 0; b64.st_size = 0; b64.st_addr = 0; b64.st_data = 0;
        b64.mem_ack = 0; b64.ld_check = 0; b64.ld_addr = 0;

        #12;
        chk("rst_req", 64'(b32.mem_req), 64'd0);
        chk("rst_empty", 64'(empty32), 64'd1);
        chk("rst_count", 64'(count32), 64'd0);
        chk("rst_ready", 64'(b32.st_ready), 64'd1);
        chk("rst_conflict", 64'(b32.ld_conflict), 64'd0);
        chk("rst_addr", 64'(b32.mem_addr), 64'd0);
        chk("rst_strb", 64'(b32.mem_wstrb), 64'd0);
        chk("rst_wdata", 64'(b32.mem_wdata), 64'd0);
        chk("rst_req64", 64'(b64.mem_req), 64'd0);
        b32.ld_check = 0;
        b32.st_size = 2'b01; b32.st_addr = 32'h1;
        #1 chk("ades_idle", 64'(b32.st_ades), 64'd0);
        @(posedge clk); #1 resetn = 1;

        // one store at a time: format, latency, single-entry drain
        for (int i = 0; i < 10; i++) begin
            tick;
            b32.st_valid = 1; b32.st_size = vt[i].size;
            b32.st_addr = vt[i].addr; b32.st_data = vt[i].data;
            @(negedge clk);
            chk("vec_ades", 64'(b32.st_ades), 64'(vt[i].ades));
            chk("vec_no_bypass", 64'(b32.mem_req), 64'd0);
            if (!vt[i].ades) sq.push_back('{64'(vt[i].eaddr), 8'(vt[i].strb), 64'(vt[i].wdata)});
            tick;
            b32.st_valid = 0;
            @(negedge clk);
            chk("vec_count", 64'(count32), 64'(sq.size()));
            if (sq.size() > 0) begin
                chk_head("vec_head", b32.mem_req, 64'(b32.mem_addr), 8'(b32.mem_wstrb), 64'(b32.mem_wdata));
                b32.mem_ack = 1;
                tick;
                b32.mem_ack = 0;
                popped = sq.pop_front();
                @(negedge clk);
            end
            chk("vec_empty", 64'(empty32), 64'd1);
        end

        // fill to DEPTH with ack held low; fifth store is held off
        tick;
        for (int i = 0; i < 5; i++) begin
            b32.st_valid = 1; b32.st_size = 2'b10;
            b32.st_addr = 32'h5000 + 32'(4*i); b32.st_data = 32'h11111111 * 32'(i+1);
            @(negedge clk);
            chk("fill_ready", 64'(b32.st_ready), 64'(i < 4));
            if (i < 4) begin
                sq.push_back('{64'(32'h5000 + 32'(4*i)), 8'hF, 64'(32'h11111111 * 32'(i+1))});
                tick;
            end
        end
        chk("full_count", 64'(count32), 64'd4);
        chk_head("full_head", b32.mem_req, 64'(b32.mem_addr), 8'(b32.mem_wstrb), 64'(b32.mem_wdata));
        // full with push and pop requested together: only the pop happens
        b32.mem_ack = 1;
        tick;
        b32.mem_ack = 0;
        popped = sq.pop_front();
        @(negedge clk);
        chk("fullpop_count", 64'(count32), 64'd3);
        chk("fullpop_ready", 64'(b32.st_ready), 64'd1);
        sq.push_back('{64'h5010, 8'hF, 64'h55555555});
        tick;
        b32.st_valid = 0;
        @(negedge clk);
        chk("refill_count", 64'(count32), 64'd4);
        for (int k = 0; k < 8 && sq.size() > 0; k++) begin
            chk_head("drain_head", b32.mem_req, 64'(b32.mem_addr), 8'(b32.mem_wstrb), 64'(b32.mem_wdata));
            b32.mem_ack = 1;
            tick;
            b32.mem_ack = 0;
            popped = sq.pop_front();
            @(negedge clk);
            chk("drain_count", 64'(count32), 64'(sq.size()));
        end
        chk("drain_done", 64'(sq.size()), 64'd0);
        chk("drain_empty", 64'(empty32), 64'd1);
        b32.mem_ack = 1;
        tick;
        b32.mem_ack = 0;
        @(negedge clk);
        chk("ack_empty_count", 64'(count32), 64'd0);
        chk("ack_empty_req", 64'(b32.mem_req), 64'd0);

        // load probe against pending and just-accepted stores
        b32.st_valid = 1; b32.st_size = 2'b10; b32.st_addr = 32'h3004; b32.st_data = 32'h77;
        b32.ld_check = 1; b32.ld_addr = 32'h3004;
        #1 chk("ld_same_cycle", 64'(b32.ld_conflict), 64'd0);
        sq.push_back('{64'h3004, 8'hF, 64'h77});
        tick;
        b32.st_valid = 0; b32.ld_addr = 32'h3006;
        @(negedge clk);
        chk("ld_hit", 64'(b32.ld_conflict), 64'd1);
        b32.ld_addr = 32'h3008;
        #1 chk("ld_miss", 64'(b32.ld_conflict), 64'd0);
        b32.ld_addr = 32'h3007; b32.ld_check = 0;
        #1 chk("ld_nocheck", 64'(b32.ld_conflict), 64'd0);
        b32.ld_check = 1; b32.ld_addr = 32'h3004; b32.mem_ack = 1;
        #1 chk("ld_popping", 64'(b32.ld_conflict), 64'd1);
        chk_head("ld_head", b32.mem_req, 64'(b32.mem_addr), 8'(b32.mem_wstrb), 64'(b32.mem_wdata));
        tick;
        b32.mem_ack = 0; b32.ld_addr = 32'h3006;
        popped = sq.pop_front();
        @(negedge clk);
        chk("ld_after_pop", 64'(b32.ld_conflict), 64'd0);
        b32.ld_check = 0;

        // 64-bit instance formatting, then async reset mid-drain
        tick;
        drive64(2'b01, 32'h4006, 64'h123456789ABCBEEF, 0, 32'h4000, 8'hC0, 64'hBEEFBEEFBEEFBEEF);
        drive64(2'b11, 32'h4004, 64'h0123456789ABCDEF, 1, 32'h0, 8'h00, 64'h0);
        drive64(2'b10, 32'h4004, 64'h00000000DEADBEEF, 0, 32'h4000, 8'hF0, 64'hDEADBEEFDEADBEEF);
        drive64(2'b11, 32'h4008, 64'h0123456789ABCDEF, 0, 32'h4008, 8'hFF, 64'h0123456789ABCDEF);
        @(negedge clk);
        chk("d64_count", 64'(count64), 64'd3);
        chk_head("d64_head", b64.mem_req, 64'(b64.mem_addr), b64.mem_wstrb, b64.mem_wdata);
        b64.mem_ack = 1;
        tick;
        b64.mem_ack = 0;
        popped = sq.pop_front();
        @(negedge clk);
        chk_head("d64_head2", b64.mem_req, 64'(b64.mem_addr), b64.mem_wstrb, b64.mem_wdata);
        #1 resetn = 0;
        #1;
        chk("arst_req", 64'(b64.mem_req), 64'd0);
        chk("arst_count", 64'(count64), 64'd0);
        chk("arst_empty", 64'(empty64), 64'd1);
        chk("arst_ready", 64'(b64.st_ready), 64'd1);
        chk("arst_wdata", b64.mem_wdata, 64'd0);
        sq.delete();
        @(posedge clk); #1 resetn = 1;
        @(negedge clk);
        chk("post_rst_req", 64'(b64.mem_req), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
